// File: rtl/act_feeder.sv
// Activation feeder: buffers up to DEPTH input vectors and streams them
// to an N-row PE array with a one-cycle-per-lane diagonal skew.
module act_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                start,
    output logic                busy,
    output logic [N-1:0]        out_valid,
    output logic [N*DATA_W-1:0] out_data,
    output logic                done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH + N);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [TW-1:0]         t;
    logic [N*DATA_W-1:0]   mem [DEPTH];

    logic                  wr_en;
    logic [CW-1:0]         post_count;
    logic                  last_step;
    logic [N-1:0]          next_valid;
    logic [N*DATA_W-1:0]   next_data;

    assign in_ready   = (state == IDLE) && (count < CW'(DEPTH));
    assign busy       = (state == STREAM);
    assign wr_en      = in_valid && in_ready;
    assign post_count = count + CW'(wr_en);
    assign last_step  = (int'(t) == int'(count) + N - 2);

    // Lane i at step t carries vector t-i; the difference is formed in signed
    // int so a lane that has not started yet can never index the buffer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        next_valid = '0;
        next_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(t) >= i && int'(t) - i < int'(count)) begin
                next_valid[i]                 = 1'b1;
                next_data[i*DATA_W +: DATA_W] = mem[AW'(int'(t) - i)][i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: the vector buffer is deliberately not reset; count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            t         <= '0;
            out_valid <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    out_valid <= '0;
                    out_data  <= '0;
                    if (wr_en) begin
                        count <= post_count;
                    end
                    if (start && post_count != '0) begin
                        state <= STREAM;
                        t     <= '0;
                    end
                end
                STREAM: begin
                    out_valid <= next_valid;
                    out_data  <= next_data;
                    if (last_step) begin
                        state <= DONE;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    out_valid <= '0;
                    out_data  <= '0;
                    count     <= '0;
                    t         <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_act_feeder.sv
// Self-checking bench for act_feeder: a queue-based reference model checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_act_feeder;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_data;
    logic             start;
    logic             busy;
    logic [N-1:0]     out_valid;
    logic [N*W-1:0]   out_data;
    logic             done;

    int errors = 0;
    int checks = 0;

    act_feeder #(.N(N), .DATA_W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .start    (start),
        .busy     (busy),
        .out_valid(out_valid),
        .out_data (out_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered vectors in a queue, and a count of edges since
    // the accepted start (-1 when idle). The skew is computed directly from
    // the stream rule: after edge s+1 of a stream, lane i shows vector s-i.
    logic [N*W-1:0] q[$];
    int             k = -1;
    int             len = 0;
    logic [N-1:0]   exp_valid = '0;
    logic [N*W-1:0] exp_data = '0;
    logic           exp_busy = 1'b0;
    logic           exp_done = 1'b0;
    logic           exp_ready = 1'b1;
    bit             armed = 1'b0;

    always @(posedge clk) begin
        exp_valid = '0;
        exp_data  = '0;
        exp_done  = 1'b0;
        if (rst) begin
            q.delete();
            k     = -1;
            armed = 1'b1;
        end else if (k < 0) begin
            if (in_valid && q.size() < DEPTH) q.push_back(in_data);
            if (start && q.size() > 0) begin
                k   = 0;
                len = q.size() + N - 1;
            end
        end else begin
            k++;
            if (k <= len) begin
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (k - 1) - i;
                    if (j >= 0 && j < q.size()) begin
                        exp_valid[i]       = 1'b1;
                        exp_data[i*W +: W] = q[j][i*W +: W];
                    end
                end
            end
            if (k == len + 1) begin
                exp_done = 1'b1;
                q.delete();
                k = -1;
            end
        end
        exp_busy  = (k >= 0) && (k < len);
        exp_ready = (k < 0) && (q.size() < DEPTH);
    end

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("out_data",  64'(out_data),  64'(exp_data));
            check("busy",      64'(busy),      64'(exp_busy));
            check("done",      64'(done),      64'(exp_done));
            check("in_ready",  64'(in_ready),  64'(exp_ready));
        end
    end

    task automatic push(input logic [N*W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles and emitted lane elements over a fixed window.
    task automatic measure(output int busy_cycles, output int elems);
        busy_cycles = 0;
        elems       = 0;
        for (int c = 0; c < DEPTH + N + 4; c++) begin
            if (busy) busy_cycles++;
            elems += $countones(out_valid);
            @(negedge clk);
        end
    endtask

    function automatic logic [N*W-1:0] full_vec(input int v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(4 * v + i + 1);
        return r;
    endfunction

    logic [N-1:0]   skew_v [5] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    logic [N*W-1:0] skew_d [5] = '{32'h0000_0001, 32'h0000_0205, 32'h0003_0600,
                                   32'h0407_0000, 32'h0800_0000};

    initial begin
        int bc;
        int el;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_done",      64'(done),      64'h0);
        check("rst_busy",      64'(busy),      64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h1);
        rst = 1'b0;
        @(negedge clk);

        // Basic skew with two vectors.
        push(32'h0403_0201);
        push(32'h0807_0605);
        pulse_start();
        check("skew_busy_t0",  64'(busy),      64'h1);
        check("skew_valid_t0", 64'(out_valid), 64'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("skew_valid", 64'(out_valid), 64'(skew_v[c]));
            check("skew_data",  64'(out_data),  64'(skew_d[c]));
        end
        check("skew_busy_last", 64'(busy), 64'h0);
        @(negedge clk);
        check("skew_done",  64'(done),     64'h1);
        check("skew_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        check("skew_done_once", 64'(done), 64'h0);

        // Full buffer: eight vectors fill it, a ninth is refused.
        for (int v = 0; v < DEPTH; v++) push(full_vec(v));
        check("full_ready", 64'(in_ready), 64'h0);
        push({N{8'hFF}});
        pulse_start();
        measure(bc, el);
        check("full_stream_cycles", 64'(bc), 64'd11);
        check("full_elements",      64'(el), 64'd32);

        // Write and start in the same cycle.
        push(32'h1413_1211);
        in_valid = 1'b1;
        in_data  = 32'h2423_2221;
        start    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        measure(bc, el);
        check("simul_stream_cycles", 64'(bc), 64'd5);
        check("simul_elements",      64'(el), 64'd8);

        // Start with an empty buffer is ignored.
        pulse_start();
        check("empty_busy", 64'(busy), 64'h0);
        measure(bc, el);
        check("empty_stream_cycles", 64'(bc), 64'd0);

        // Reset at stream step 2, then a fresh stream.
        push(32'h3433_3231);
        push(32'h4443_4241);
        push(32'h5453_5251);
        pulse_start();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(out_valid), 64'h0);
        check("abort_busy",  64'(busy),      64'h0);
        rst = 1'b0;
        check("abort_ready", 64'(in_ready), 64'h1);
        measure(bc, el);
        check("abort_no_stream", 64'(bc), 64'd0);
        push(32'h6463_6261);
        push(32'h7473_7271);
        pulse_start();
        measure(bc, el);
        check("fresh_stream_cycles", 64'(bc), 64'd5);
        check("fresh_elements",      64'(el), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter: N, default 4, number of lanes (one per PE row).
REQ-002 Parameter: DATA_W, default 8, activation width in bits.
REQ-003 Parameter: DEPTH, default 8, vector buffer capacity (power of two, at least 2).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input vector offered.
- in_ready  output  1  buffer can accept a vector (combinational from state and count).
- in_data  input  N*DATA_W  input vector; lane i occupies bits [i*DATA_W +: DATA_W].
- start  input  1  single-cycle request to begin streaming the buffered vectors.
- busy  output  1  high in STREAM.
- out_valid  output  N  per-lane valid to the PE array, registered.
- out_data  output  N*DATA_W  per-lane activation to the PE array, registered; lane packing as in_data.
- done  output  1  one-cycle pulse after the last skewed element leaves.

Function
REQ-005 States SHALL be IDLE, STREAM and DONE.
REQ-006 A vector SHALL be written into buffer slot count when in_valid && in_ready, and count SHALL increment by 1.
REQ-007 in_ready SHALL equal (state==IDLE) && (count<DEPTH), so in_ready is 0 when full, in STREAM and in DONE.
REQ-008 IDLE->STREAM SHALL occur on start when the post-write count is nonzero; a write in the same cycle as start SHALL be accepted and included in the stream.
REQ-009 start SHALL be ignored when count==0 after any same-cycle write, and in STREAM and DONE.
REQ-010 In STREAM, step counter t SHALL run 0..count+N-2, advancing by one each cycle, which gives L=count+N-1 stream cycles.
REQ-011 For step t and lane i, if 0 <= t-i < count, the next-cycle out_data lane i SHALL be element i of vector t-i and out_valid[i] SHALL be 1; otherwise that lane SHALL output 0 with out_valid[i]=0.
REQ-012 Latency: the start edge latches state; lane-0 data for vector 0 SHALL appear on the first clock edge after the start cycle; lane i SHALL lag lane 0 by exactly i cycles.
REQ-013 After step t=L-1, the block SHALL enter DONE; in DONE, done SHALL be 1, out_valid SHALL be all 0, count SHALL clear to 0, and the next state SHALL be IDLE.
REQ-014 busy SHALL be 1 exactly in STREAM.
REQ-015 Buffer contents SHALL be unchanged during STREAM; in_valid there SHALL have no effect.
REQ-016 The buffer SHALL hold no wrap-around data; each stream SHALL use slots 0..count-1 only, and slots at or above count SHALL never be emitted.
REQ-017 Outputs SHALL NOT change in IDLE: out_valid SHALL be 0 and out_data SHALL be 0.
REQ-018 Arithmetic: t SHALL be at least clog2(DEPTH+N) bits and count at least clog2(DEPTH+1) bits; the t-i comparisons SHALL be signed or guarded so that negative values are never used as indices.

Reset
REQ-019 rst high at a clock edge SHALL force state=IDLE, count=0, t=0, out_valid=0, out_data=0 and done=0, in any state including mid-STREAM; buffer contents need not be cleared.
REQ-020 After rst deasserts, in_ready SHALL be 1 in the same cycle and no done pulse SHALL be produced for an aborted stream.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: hold rst 2 cycles -> out_valid=0000, done=0, busy=0, in_ready=1.
- Basic skew: N=4, load 2 vectors {1,2,3,4} and {5,6,7,8} (lane0 first), pulse start -> over 5 stream cycles lane0 shows 1,5,-,-,-; lane1 -,2,6,-,-; lane2 -,-,3,7,-; lane3 -,-,-,4,8; then done pulses once, busy falls, in_ready returns to 1.
- Full buffer: write 8 vectors -> in_ready=0 after the 8th; a 9th in_valid is not accepted; start gives 11 stream cycles and all 32 elements arrive in order.
- Simultaneous write and start: one buffered vector, then in_valid and start in the same cycle -> 2 vectors streamed, L=5.
- Start with empty buffer: start with count=0 -> stays IDLE, no busy, no done.
- Reset mid-stream: assert rst at stream step 2 -> next edge shows out_valid=0 and busy=0; no done pulse; a fresh load and start then streams correctly.
